// File: rtl/param_fifo_pkg.sv
// Common types and defaults for the parameterised FIFO.
`include "fifo_pkg.vh"

package param_fifo_pkg;

    localparam int DEF_DATA_WIDTH = `FIFO_DEF_DATA_WIDTH;
    localparam int DEF_DEPTH      = `FIFO_DEF_DEPTH;
    localparam int DEF_AEMPTY_TH  = 2;

    // Encoded as {write_accepted, read_accepted}
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_RD   = 2'b01,
        OP_WR   = 2'b10,
        OP_RW   = 2'b11
    } fifo_op_e;

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: one write port, one asynchronous read port, no reset.
module fifo_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/fifo_pkg.vh
// Shared log2 macro and default FIFO geometry.
`ifndef FIFO_PKG_VH
`define FIFO_PKG_VH

`define FIFO_LOG2(x) $clog2(x)
`define FIFO_DEF_DATA_WIDTH 8
`define FIFO_DEF_DEPTH 32

`endif

// File: rtl/param_fifo.sv
// Synchronous FIFO with status/error flags; define PARAM_FIFO_FWFT_EN
// for first-word-fall-through output, otherwise dout is registered.
`include "fifo_pkg.vh"

module param_fifo
    import param_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int AFULL_TH   = DEPTH - 2,
    parameter int AEMPTY_TH  = DEF_AEMPTY_TH,
    parameter int ADDR_WIDTH = `FIFO_LOG2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    output logic                  full,
    output logic                  almost_full,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  clr_err
);

    localparam logic [ADDR_WIDTH:0] PTR_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0] AFULL_V  = AFULL_TH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AEMPTY_V = AEMPTY_TH[ADDR_WIDTH:0];

    logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  wr_acc, rd_acc;
    logic [DATA_WIDTH-1:0] rd_data;
    fifo_op_e              op;

    // Extra pointer MSB tells a full ring from an empty one
    assign count = wr_ptr_q - rd_ptr_q;
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]) &&
                   (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]);
    assign almost_full  = (count >= AFULL_V);
    assign almost_empty = (count <= AEMPTY_V);
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    assign wr_acc = wr_en & ~full & ~flush;
    assign rd_acc = rd_en & ~empty & ~flush;
    assign op     = fifo_op_e'({wr_acc, rd_acc});

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            unique case (op)
                OP_IDLE: ;
                OP_WR:   wr_ptr_d = wr_ptr_q + PTR_ONE;
                OP_RD:   rd_ptr_d = rd_ptr_q + PTR_ONE;
                OP_RW: begin
                    wr_ptr_d = wr_ptr_q + PTR_ONE;
                    rd_ptr_d = rd_ptr_q + PTR_ONE;
                end
            endcase
        end
    end

    // A fresh error wins over a same-cycle clear
    always_comb begin
        overflow_d  = (overflow_q & ~clr_err) | (wr_en & full);
        underflow_d = (underflow_q & ~clr_err) | (rd_en & empty);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr_q[ADDR_WIDTH-1:0]),
        .wr_data (din),
        .rd_addr (rd_ptr_q[ADDR_WIDTH-1:0]),
        .rd_data (rd_data)
    );

`ifdef PARAM_FIFO_FWFT_EN
    assign dout       = rd_data;
    assign dout_valid = ~empty;
`else
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  dout_valid_q, dout_valid_d;

    always_comb begin
        dout_d       = dout_q;
        dout_valid_d = rd_acc;
        if (rd_acc) begin
            dout_d = rd_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
`endif

endmodule

// File: tb/tb_param_fifo.sv
// Scoreboard bench for param_fifo in registered-output mode.
module tb_param_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 32;
    localparam int AW    = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          wr_en = 1'b0;
    logic          rd_en = 1'b0;
    logic          clr_err = 1'b0;
    logic [DW-1:0] din = '0;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic          full, almost_full, empty, almost_empty;
    logic [AW:0]   count;
    logic          overflow, underflow;

    int n_cmp = 0;
    int n_err = 0;
    logic [DW-1:0] mq[$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] last_dout = '0;

    param_fifo #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .wr_en        (wr_en),
        .din          (din),
        .rd_en        (rd_en),
        .dout         (dout),
        .dout_valid   (dout_valid),
        .full         (full),
        .almost_full  (almost_full),
        .empty        (empty),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow),
        .clr_err      (clr_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // Issue one cycle of stimulus; the reference queue decides acceptance
    task automatic step(input logic w, input logic r, input logic [DW-1:0] d,
                        input logic f, input logic c);
        bit wa, ra;
        wr_en = w; rd_en = r; din = d; flush = f; clr_err = c;
        ra = r && !f && (mq.size() > 0);
        wa = w && !f && (mq.size() < DEPTH);
        if (f) begin
            mq.delete();
        end else begin
            if (ra) begin
                last_dout = mq[0];
                exp_q.push_back(mq.pop_front());
            end
            if (wa) mq.push_back(d);
        end
        @(posedge clk); #1;
        wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; clr_err = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n && dout_valid) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_dout: got %0h required none", dout);
            end else begin
                logic [DW-1:0] e;
                e = exp_q.pop_front();
                if (dout !== e) begin
                    n_err++;
                    $display("FAIL dout_order: got %0h required %0h", dout, e);
                end
            end
        end
    end

    initial begin
        logic [DW-1:0] v;
        #12;
        check("rst_empty", empty, 1);
        check("rst_aempty", almost_empty, 1);
        check("rst_full", full, 0);
        check("rst_afull", almost_full, 0);
        check("rst_count", count, 0);
        check("rst_dout", dout, 0);
        check("rst_dv", dout_valid, 0);
        check("rst_ovf", overflow, 0);
        check("rst_udf", underflow, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic in-order traffic
        step(1, 0, 8'h11, 0, 0);
        step(1, 0, 8'h22, 0, 0);
        step(1, 0, 8'h33, 0, 0);
        step(1, 0, 8'h44, 0, 0);
        check("four_count", count, 4);
        check("four_aempty", almost_empty, 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 8'h00, 0, 0);
            check("rd_dv", dout_valid, 1);
        end
        step(0, 0, 8'h00, 0, 0);
        check("four_dv_drop", dout_valid, 0);
        check("four_empty", empty, 1);

        // Fill to full with threshold checks
        for (int i = 0; i < DEPTH; i++) begin
            v = 8'(8'h80 + i);
            step(1, 0, v, 0, 0);
            check("fill_count", count, i + 1);
            check("fill_afull", almost_full, (i + 1) >= 30);
            check("fill_aempty", almost_empty, (i + 1) <= 2);
            check("fill_full", full, (i + 1) == DEPTH);
        end
        step(1, 0, 8'hEE, 0, 0);
        check("ovf_count", count, 32);
        check("ovf_set", overflow, 1);
        step(1, 0, 8'hEE, 0, 1);
        check("ovf_clr_race", overflow, 1);
        step(0, 0, 8'h00, 0, 1);
        check("ovf_clr", overflow, 0);

        // Full: simultaneous read and write
        step(1, 1, 8'hEE, 0, 0);
        check("full_rw_count", count, 31);
        check("full_rw_ovf", overflow, 1);
        step(0, 0, 8'h00, 0, 1);
        for (int i = 0; i < 15; i++) step(0, 1, 8'h00, 0, 0);
        check("half_count", count, 16);
        step(1, 1, 8'h5A, 0, 0);
        check("half_rw_count", count, 16);
        check("half_rw_ovf", overflow, 0);
        for (int i = 0; i < 16; i++) step(0, 1, 8'h00, 0, 0);
        check("drain_empty", empty, 1);
        check("drain_count", count, 0);

        // Empty: underflow behaviour
        step(0, 1, 8'h00, 0, 0);
        check("udf_set", underflow, 1);
        check("udf_dv", dout_valid, 0);
        check("udf_dout_hold", dout, last_dout);
        step(0, 0, 8'h00, 0, 1);
        check("udf_clr", underflow, 0);
        step(1, 1, 8'h3C, 0, 0);
        check("empty_rw_count", count, 1);
        check("empty_rw_udf", underflow, 1);
        step(0, 1, 8'h00, 0, 1);
        check("empty_rw_drain", count, 0);

        // Interleaved traffic across pointer wrap
        for (int i = 0; i < 3; i++) step(1, 0, 8'(i * 5 + 1), 0, 0);
        for (int i = 3; i < 40; i++) begin
            step(1, 1, 8'(i * 5 + 1), 0, 0);
            check("wrap_count", count, 3);
        end
        for (int i = 0; i < 3; i++) step(0, 1, 8'h00, 0, 0);
        check("wrap_end_empty", empty, 1);

        // Flush overrides concurrent requests
        for (int i = 0; i < 10; i++) step(1, 0, 8'(8'hC0 + i), 0, 0);
        check("pre_flush_count", count, 10);
        step(1, 1, 8'hFF, 1, 0);
        check("flush_count", count, 0);
        check("flush_empty", empty, 1);
        check("flush_dv", dout_valid, 0);
        step(0, 0, 8'h00, 0, 0);
        check("flush_dout_hold", dout, last_dout);

        // Asynchronous reset mid-burst
        for (int i = 0; i < 5; i++) step(1, 0, 8'(8'h60 + i), 0, 0);
        step(1, 1, 8'h70, 0, 0);
        step(1, 1, 8'h71, 0, 0);
        check("pre_rst_ovf", overflow, 0);
        wr_en = 1'b1; rd_en = 1'b1; din = 8'h72;
        #2 rst_n = 1'b0;
        #1;
        mq.delete();
        exp_q.delete();
        check("arst_count", count, 0);
        check("arst_empty", empty, 1);
        check("arst_aempty", almost_empty, 1);
        check("arst_full", full, 0);
        check("arst_afull", almost_full, 0);
        check("arst_dout", dout, 0);
        check("arst_dv", dout_valid, 0);
        check("arst_udf", underflow, 0);
        wr_en = 1'b0; rd_en = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        step(0, 0, 8'h00, 0, 0);
        check("post_rst_empty", empty, 1);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
